// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register over a req/ack imem port, one request outstanding; a word reaches decode
// on its ack edge. A decode stall parks one word in a hold buffer and pauses fetch until decode frees up.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        CLKF,
  input  logic        RST_nF,
  input  logic        StallD,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  input  logic        JumpD,
  input  logic [31:0] PCJumpD,
  output logic        ImemReqF,
  output logic [31:0] ImemAddrF,
  input  logic        ImemAckF,
  input  logic [31:0] ImemRdataF,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]  state, stateNext;
  logic [31:0] pcF, pcNext, addrNext, pcPlus4, target;
  logic [31:0] bufInstr, bufPcPlus4;
  logic [31:0] deliverInstr, deliverPc4;
  logic        redirect, deliver, bufLoad;

  // Only an instruction actually leaving decode may steer the PC.
  assign redirect = (JumpD | PCSrcD) & ValidD & ~StallD;
  assign target   = JumpD ? PCJumpD : PCBranchD;
  assign pcPlus4  = pcF + 32'd4;
  assign ImemReqF = (state == REQ) | (state == DRAIN);

  always_comb begin
    stateNext    = state;
    pcNext       = pcF;
    addrNext     = ImemAddrF;
    deliver      = 1'b0;
    deliverInstr = ImemRdataF;
    deliverPc4   = pcPlus4;
    bufLoad      = 1'b0;
    case (state)
      IDLE: begin
        stateNext = REQ;
        addrNext  = pcF;
      end
      REQ: begin
        if (ImemAckF) begin
          if (redirect) begin
            pcNext   = target;
            addrNext = target;
          end else begin
            pcNext   = pcPlus4;
            addrNext = pcPlus4;
            if (StallD) begin
              bufLoad   = 1'b1;
              stateNext = HOLD;
            end else begin
              deliver = 1'b1;
            end
          end
        end else if (redirect) begin
          // Address must stay put until the in-flight wrong-path word returns.
          pcNext    = target;
          stateNext = DRAIN;
        end
      end
      DRAIN: begin
        if (redirect) pcNext = target;
        if (ImemAckF) begin
          addrNext  = redirect ? target : pcF;
          stateNext = REQ;
        end
      end
      HOLD: begin
        if (redirect) begin
          pcNext    = target;
          addrNext  = target;
          stateNext = REQ;
        end else if (!StallD) begin
          deliver      = 1'b1;
          deliverInstr = bufInstr;
          deliverPc4   = bufPcPlus4;
          addrNext     = pcF;
          stateNext    = REQ;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLKF or negedge RST_nF) begin
    if (!RST_nF) begin
      state      <= IDLE;
      pcF        <= RESET_PC;
      ImemAddrF  <= RESET_PC;
      InstrD     <= 32'd0;
      PCPlus4D   <= 32'd0;
      ValidD     <= 1'b0;
      bufInstr   <= 32'd0;
      bufPcPlus4 <= 32'd0;
    end else begin
      state     <= stateNext;
      pcF       <= pcNext;
      ImemAddrF <= addrNext;
      if (bufLoad) begin
        bufInstr   <= ImemRdataF;
        bufPcPlus4 <= pcPlus4;
      end
      if (!StallD) begin
        if (deliver) begin
          InstrD   <= deliverInstr;
          PCPlus4D <= deliverPc4;
          ValidD   <= 1'b1;
        end else begin
          InstrD <= 32'd0;
          ValidD <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: randomized imem latency, decode stalls and redirects, scored against program order.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        CLKF = 1'b0;
  logic        RST_nF = 1'b0;
  logic        StallD = 1'b0, PCSrcD = 1'b0, JumpD = 1'b0, ImemAckF = 1'b0;
  logic [31:0] PCBranchD = '0, PCJumpD = '0, ImemRdataF = '0;
  logic        ImemReqF, ValidD;
  logic [31:0] ImemAddrF, InstrD, PCPlus4D;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .CLKF(CLKF), .RST_nF(RST_nF), .StallD(StallD), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
    .JumpD(JumpD), .PCJumpD(PCJumpD), .ImemReqF(ImemReqF), .ImemAddrF(ImemAddrF),
    .ImemAckF(ImemAckF), .ImemRdataF(ImemRdataF), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD)
  );

  always #5 CLKF = ~CLKF;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == RESET_PC) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Architectural model: the PC decode should see next, and the one imem request in flight.
  logic [31:0] expPc;
  logic        reqActive;
  logic [31:0] reqAddr;
  int          reqLeft;
  int          latMin, latMax, stallPct, brPct, sinceConsume;
  logic        fArm, fBr, fJmp, consumed;
  logic [31:0] fBrT, fJmpT, consumedPc4, pc4, saved;

  task automatic step();
    @(negedge CLKF);
    consumed = 1'b0;
    if (!ValidD) check("bubbleInstr", InstrD, 32'd0);
    if (reqActive) check("reqHeld", 32'(ImemReqF), 32'd1);
    ImemAckF = 1'b0;
    ImemRdataF = $urandom;
    if (ImemReqF) begin
      if (!reqActive) begin
        reqActive = 1'b1;
        reqAddr   = ImemAddrF;
        reqLeft   = int'($urandom_range(latMax, latMin));
      end else begin
        check("addrStable", ImemAddrF, reqAddr);
      end
      if (reqLeft == 0) begin
        ImemAckF   = 1'b1;
        ImemRdataF = memWord(reqAddr);
        reqActive  = 1'b0;
      end else begin
        reqLeft--;
      end
    end
    StallD    = int'($urandom_range(99, 0)) < stallPct;
    PCSrcD    = int'($urandom_range(99, 0)) < brPct;
    JumpD     = int'($urandom_range(99, 0)) < brPct / 2;
    PCBranchD = RESET_PC + ($urandom_range(63, 0) << 2);
    PCJumpD   = RESET_PC + ($urandom_range(63, 0) << 2);
    if (fArm && ValidD && !StallD) begin
      PCSrcD = fBr; JumpD = fJmp; PCBranchD = fBrT; PCJumpD = fJmpT;
      fArm = 1'b0;
    end
    if (ValidD && !StallD) begin
      check("pcPlus4", PCPlus4D, expPc + 32'd4);
      check("instr", InstrD, memWord(expPc));
      consumed     = 1'b1;
      consumedPc4  = PCPlus4D;
      sinceConsume = 0;
      if (JumpD) expPc = PCJumpD;
      else if (PCSrcD) expPc = PCBranchD;
      else expPc = expPc + 32'd4;
    end else begin
      sinceConsume++;
      if (sinceConsume > 100) begin
        check("progress", 32'(ValidD), 32'd1);
        sinceConsume = 0;
      end
    end
  endtask

  task automatic runUntilConsume(input string tag, output logic [31:0] pc4Out);
    logic done;
    done   = 1'b0;
    pc4Out = '0;
    for (int i = 0; i < 60 && !done; i++) begin
      step();
      if (consumed) begin
        done   = 1'b1;
        pc4Out = consumedPc4;
      end
    end
    if (!done) check({tag, "Timeout"}, 32'(ValidD), 32'd1);
  endtask

  task automatic doReset();
    RST_nF = 1'b0;
    StallD = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0; ImemAckF = 1'b0;
    reqActive = 1'b0; expPc = RESET_PC; fArm = 1'b0; sinceConsume = 0;
    repeat (2) @(negedge CLKF);
    check("rstReq", 32'(ImemReqF), 32'd0);
    check("rstAddr", ImemAddrF, RESET_PC);
    check("rstInstr", InstrD, 32'd0);
    check("rstPc4", PCPlus4D, 32'd0);
    check("rstValid", 32'(ValidD), 32'd0);
    RST_nF = 1'b1;
  endtask

  initial begin
    stallPct = 0; brPct = 0; latMin = 2; latMax = 2;
    fBr = 1'b0; fJmp = 1'b0; fBrT = '0; fJmpT = '0;
    doReset();

    // First fetch after reset, two-cycle imem.
    step();
    check("t1Req", 32'(ImemReqF), 32'd1);
    check("t1Addr", ImemAddrF, RESET_PC);
    runUntilConsume("t1", pc4);
    check("t1Instr", InstrD, 32'h2008_0005);
    check("t1Pc4", pc4, 32'h0040_0004);
    check("t1NextAddr", ImemAddrF, 32'h0040_0004);

    // Stall across the ack of 0x00400004: word parked, fetch paused.
    stallPct = 100;
    step();
    saved = InstrD;
    step();
    step();
    check("t2NoReq", 32'(ImemReqF), 32'd0);
    check("t2Held", InstrD, saved);
    stallPct = 0;
    runUntilConsume("t2", pc4);
    check("t2Pc4", pc4, 32'h0040_0008);
    check("t2NextAddr", ImemAddrF, 32'h0040_0008);
    runUntilConsume("t2b", pc4);
    check("t2NoRefetch", pc4, 32'h0040_000C);

    // Taken branch with ack in the same cycle.
    latMin = 0; latMax = 0;
    fArm = 1'b1; fBr = 1'b1; fJmp = 1'b0; fBrT = 32'h0040_0040;
    runUntilConsume("t3a", pc4);
    step();
    check("t3Addr", ImemAddrF, 32'h0040_0040);
    check("t3Bubble", 32'(ValidD), 32'd0);
    runUntilConsume("t3", pc4);
    check("t3Pc4", pc4, 32'h0040_0044);

    // Jump beats branch.
    fArm = 1'b1; fBr = 1'b1; fJmp = 1'b1; fBrT = 32'h0040_0200; fJmpT = 32'h0040_0100;
    runUntilConsume("t5a", pc4);
    runUntilConsume("t5", pc4);
    check("t5Jump", pc4, 32'h0040_0104);

    // Redirect while a slow request is in flight: drain it, then fetch the target.
    latMin = 4; latMax = 4;
    fArm = 1'b1; fBr = 1'b1; fJmp = 1'b0; fBrT = 32'h0040_0080;
    runUntilConsume("t4a", pc4);
    saved = reqAddr;
    step();
    check("t4AddrHeld", ImemAddrF, saved);
    check("t4Bubble", 32'(ValidD), 32'd0);
    runUntilConsume("t4", pc4);
    check("t4Pc4", pc4, 32'h0040_0084);

    // PC wraps at the top of the address space.
    latMin = 1; latMax = 1;
    fArm = 1'b1; fBr = 1'b0; fJmp = 1'b1; fJmpT = 32'hFFFF_FFFC;
    runUntilConsume("t6a", pc4);
    runUntilConsume("t6", pc4);
    check("t6WrapPc4", pc4, 32'd0);
    check("t6WrapAddr", ImemAddrF, 32'd0);
    runUntilConsume("t6b", pc4);
    check("t6AfterWrap", pc4, 32'd4);

    // Asynchronous reset in the middle of a drain.
    latMin = 4; latMax = 4;
    fArm = 1'b1; fBr = 1'b1; fJmp = 1'b0; fBrT = 32'h0040_0080;
    runUntilConsume("t7a", pc4);
    @(posedge CLKF);
    #2;
    check("t7InDrain", 32'(ImemReqF), 32'd1);
    RST_nF = 1'b0;
    #1;
    check("t7Req", 32'(ImemReqF), 32'd0);
    check("t7Addr", ImemAddrF, RESET_PC);
    check("t7Instr", InstrD, 32'd0);
    check("t7Pc4", PCPlus4D, 32'd0);
    check("t7Valid", 32'(ValidD), 32'd0);
    doReset();

    // Random traffic.
    stallPct = 30; brPct = 15; latMin = 0; latMax = 3;
    repeat (3000) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
